// File: rtl/spike_cnt_pkg.sv
// Shared constants, result type and helpers for the spike window counter.
//   POP_GRP  : neurons per popcount group
//   PIPE_LAT : cycles from last window sample to o_valid
//   clog2    : ceiling log2 for width derivation
//   sat_add  : unsigned add clamped to 2^w-1, reports whether it clamped
package spike_cnt_pkg;

  localparam int unsigned POP_GRP  = 16;
  localparam int unsigned PIPE_LAT = 3;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } sat_res_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

  localparam int unsigned GRP_CW = clog2(POP_GRP + 1);

  function automatic sat_res_t sat_add(input logic [31:0] acc, input logic [31:0] inc,
                                       input int unsigned w);
    logic [32:0] sum;
    logic [32:0] mx;
    sat_res_t    r;
    sum = 33'(acc) + 33'(inc);
    mx  = (33'(1) << w) - 33'(1);
    if (sum > mx) begin
      r.sat = 1'b1;
      r.val = mx[31:0];
    end else begin
      r.sat = 1'b0;
      r.val = sum[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_cnt_window_popcount_grp.sv
// Combinational popcount of one 16-neuron group.
//   bits  : spike bits of the group
//   cnt_c : number of set bits
module popcount_grp
  import spike_cnt_pkg::*;
(
  input  logic [POP_GRP-1:0] bits,
  output logic [GRP_CW-1:0]  cnt_c
);

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < POP_GRP; i++) cnt_c = cnt_c + GRP_CW'(bits[i]);
  end

endmodule

// File: rtl/spike_cnt_window.sv
// Counts spike pulses over fixed windows of WIN_CYCLES clocks and emits one
// count per window with a one-cycle strobe, three cycles after the window's
// last sample. Optional per-neuron mask under `SPIKE_CNT_MASK_EN.
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : 1 = counting; 0 = windowing halted and cleared
//   spike_in     : one-cycle spike pulses, bit i = neuron i
//   i_mask       : (SPIKE_CNT_MASK_EN only) registered per-neuron count enable
//   o_spike_cnt  : count of the last completed window, zero-extended
//   o_valid      : strobe, o_spike_cnt updated this cycle
//   o_sat        : reported window saturated; held until next strobe
module spike_cnt_window
  import spike_cnt_pkg::*;
#(
  parameter int unsigned N_NEURON   = 128,
  parameter int unsigned WIN_CYCLES = 1000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_NEURON-1:0] spike_in,
`ifdef SPIKE_CNT_MASK_EN
  input  logic [N_NEURON-1:0] i_mask,
`endif
  output logic [31:0]         o_spike_cnt,
  output logic                o_valid,
  output logic                o_sat
);

  localparam int unsigned NGRP  = N_NEURON / POP_GRP;
  localparam int unsigned SUM_W = clog2(N_NEURON + 1);
  localparam int unsigned WIN_W = (WIN_CYCLES > 2) ? clog2(WIN_CYCLES) : 1;

  logic [WIN_W-1:0]              win_cnt;
  logic                          win_end_c;
  logic [N_NEURON-1:0]           masked_c;
  logic [NGRP-1:0][GRP_CW-1:0]   grp_cnt_c;
  logic [NGRP-1:0][GRP_CW-1:0]   s1_cnt;
  logic                          s1_end;
  logic [SUM_W-1:0]              sum_c;
  logic [SUM_W-1:0]              s2_sum;
  logic                          s2_end;
  logic [CNT_W-1:0]              acc;
  logic                          acc_sat;
  sat_res_t                      res_c;

`ifdef SPIKE_CNT_MASK_EN
  logic [N_NEURON-1:0] mask_q;

  // Mask register; a new value applies to the sample cycle after it lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '0;
    else       mask_q <= i_mask;
  end

  assign masked_c = spike_in & mask_q;
`else
  assign masked_c = spike_in;
`endif

  // Window position; restarts at 0 whenever counting is halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   win_cnt <= '0;
    else if (!enable)                            win_cnt <= '0;
    else if (win_cnt == WIN_W'(WIN_CYCLES - 1))  win_cnt <= '0;
    else                                         win_cnt <= win_cnt + WIN_W'(1);
  end

  assign win_end_c = enable && (win_cnt == WIN_W'(WIN_CYCLES - 1));

  for (genvar g = 0; g < NGRP; g++) begin : g_pop
    popcount_grp u_pop (
      .bits  (masked_c[g*POP_GRP +: POP_GRP]),
      .cnt_c (grp_cnt_c[g])
    );
  end

  // S1: group popcounts with the window-end flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      s1_cnt <= '0;
      s1_end <= 1'b0;
    end else begin
      s1_cnt <= grp_cnt_c;
      s1_end <= win_end_c;
    end
  end

  always_comb begin
    sum_c = '0;
    for (int g = 0; g < NGRP; g++) sum_c = sum_c + SUM_W'(s1_cnt[g]);
  end

  // S2: per-cycle total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      s2_sum <= '0;
      s2_end <= 1'b0;
    end else begin
      s2_sum <= sum_c;
      s2_end <= s1_end;
    end
  end

  assign res_c = sat_add(32'(acc), 32'(s2_sum), CNT_W);

  // S3: accumulate; at window end publish acc+sum and restart acc at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      acc_sat     <= 1'b0;
      o_spike_cnt <= '0;
      o_valid     <= 1'b0;
      o_sat       <= 1'b0;
    end else if (!enable) begin
      acc     <= '0;
      acc_sat <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= s2_end;
      if (s2_end) begin
        o_spike_cnt <= res_c.val;
        o_sat       <= res_c.sat | acc_sat;
        acc         <= '0;
        acc_sat     <= 1'b0;
      end else begin
        acc     <= CNT_W'(res_c.val);
        acc_sat <= acc_sat | res_c.sat;
      end
    end
  end

endmodule

// File: tb/tb_spike_cnt_window.sv
// Bench for spike_cnt_window: two instances (32-bit and 8-bit accumulators)
// share stimulus; a window-level reference model queues expected strobes and
// a negedge monitor compares them. Build with SPIKE_CNT_MASK_EN for the mask.
module tb_spike_cnt_window;

  localparam int N   = 128;
  localparam int WIN = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  spike_in;
`ifdef SPIKE_CNT_MASK_EN
  logic [N-1:0]  mask;
`endif
  logic [31:0]   cnt_a, cnt_b;
  logic          vld_a, vld_b, sat_a, sat_b;

  always #5 clk = ~clk;

  spike_cnt_window #(.N_NEURON(N), .WIN_CYCLES(WIN), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
`ifdef SPIKE_CNT_MASK_EN
    .i_mask(mask),
`endif
    .o_spike_cnt(cnt_a), .o_valid(vld_a), .o_sat(sat_a));

  spike_cnt_window #(.N_NEURON(N), .WIN_CYCLES(WIN), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
`ifdef SPIKE_CNT_MASK_EN
    .i_mask(mask),
`endif
    .o_spike_cnt(cnt_b), .o_valid(vld_b), .o_sat(sat_b));

  typedef struct { longint sum; int due; } exp_t;
  typedef struct { longint sum; int due; int age; } pend_t;

  exp_t   qs[2][$];
  pend_t  pend[$];
  longint mx[2] = '{64'hFFFF_FFFF, 64'd255};
  longint last_c[2];
  logic   last_s[2];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  // Reference model state: consecutive enabled cycles and window spike total.
  int           run = 0;
  longint       acc_m = 0;
  logic [N-1:0] mask_m = '1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int d, input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d actual %0d required %0d", nm, d, cyc, act, exp);
    end
  endtask

  // One clock of stimulus plus the model's view of it.
  task automatic cycle(input logic en, input logic rst, input logic [N-1:0] sp);
    enable = en; reset = rst; spike_in = sp;
    if (rst) begin
      qs[0].delete(); qs[1].delete(); pend.delete();
      run = 0; acc_m = 0;
    end else if (!en) begin
      pend.delete();
      run = 0; acc_m = 0;
    end else begin
      // A finished window reports only if two more enabled cycles follow it.
      foreach (pend[i]) pend[i].age++;
      while (pend.size() > 0 && pend[0].age == 2) begin
        pend_t p = pend.pop_front();
        qs[0].push_back('{p.sum, p.due});
        qs[1].push_back('{p.sum, p.due});
      end
      acc_m += $countones(sp & mask_m);
      run++;
      if (run % WIN == 0) begin
        pend.push_back('{acc_m, cyc + 3, 0});
        acc_m = 0;
      end
    end
`ifdef SPIKE_CNT_MASK_EN
    mask_m = rst ? '0 : mask;
`endif
    @(posedge clk); #1;
  endtask

  function automatic logic [N-1:0] rnd_spk(input int mode);
    logic [N-1:0] v;
    for (int w = 0; w < N / 32; w++) begin
      case (mode)
        0:       v[w*32 +: 32] = $urandom & $urandom & $urandom;
        1:       v[w*32 +: 32] = $urandom | $urandom;
        2:       v[w*32 +: 32] = '1;
        default: v[w*32 +: 32] = '0;
      endcase
    end
    return v;
  endfunction

  // Monitor: pops an expectation on every strobe, checks hold otherwise.
  always @(negedge clk) begin
    logic [31:0] c[2];
    logic        v[2], s[2];
    exp_t        e;
    longint      ec;
    c[0] = cnt_a; c[1] = cnt_b;
    v[0] = vld_a; v[1] = vld_b;
    s[0] = sat_a; s[1] = sat_b;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk(d, "reset_valid", longint'(v[d]), 0);
        chk(d, "reset_cnt", longint'(c[d]), 0);
        chk(d, "reset_sat", longint'(s[d]), 0);
        last_c[d] = 0; last_s[d] = 1'b0;
      end else begin
        if (qs[d].size() > 0 && qs[d][0].due < cyc) begin
          checks++; errors++;
          $display("FAIL missing_strobe dut%0d actual none required strobe at cycle %0d",
                   d, qs[d][0].due);
          void'(qs[d].pop_front());
        end
        if (v[d]) begin
          if (qs[d].size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_strobe dut%0d cycle %0d actual strobe cnt %0d required none",
                     d, cyc, c[d]);
          end else begin
            e  = qs[d].pop_front();
            ec = (e.sum > mx[d]) ? mx[d] : e.sum;
            chk(d, "strobe_cycle", longint'(cyc), longint'(e.due));
            chk(d, "count", longint'(c[d]), ec);
            chk(d, "sat", longint'(s[d]), longint'(e.sum > mx[d]));
            last_c[d] = ec; last_s[d] = (e.sum > mx[d]);
          end
        end else begin
          chk(d, "hold_cnt", longint'(c[d]), last_c[d]);
          chk(d, "hold_sat", longint'(s[d]), longint'(last_s[d]));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] ones;
    logic [N-1:0] z;
    ones = '1; z = '0;
    enable = 1'b0; reset = 1'b1; spike_in = '0;
`ifdef SPIKE_CNT_MASK_EN
    mask = '1;
`endif
    @(posedge clk); #1;
    repeat (3) cycle(1'b0, 1'b1, z);

    // Single burst at window position 3.
    for (int i = 0; i < WIN; i++) cycle(1'b1, 1'b0, (i == 3) ? ones : z);
    // Three fully active windows.
    for (int i = 0; i < 3 * WIN; i++) cycle(1'b1, 1'b0, ones);
    // Five spikes, saturation must clear on the 8-bit instance.
    for (int i = 0; i < WIN; i++) cycle(1'b1, 1'b0, (i == 0) ? N'(5'h1F) : z);
    // Boundary: 1 spike at position 9, 2 spikes at the next position 0.
    for (int i = 0; i < WIN - 1; i++) cycle(1'b1, 1'b0, z);
    cycle(1'b1, 1'b0, N'(1));
    cycle(1'b1, 1'b0, N'(3));
    for (int i = 0; i < WIN - 1; i++) cycle(1'b1, 1'b0, z);
    // Abort at position 6 for 4 cycles; spikes while halted are ignored.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, rnd_spk(0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, ones);
    for (int i = 0; i < WIN + 4; i++) cycle(1'b1, 1'b0, (i < 3) ? N'(7) : z);
    // Reset mid-window.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, ones);
    cycle(1'b1, 1'b1, ones);
    cycle(1'b0, 1'b1, ones);
    for (int i = 0; i < WIN + 4; i++) cycle(1'b1, 1'b0, N'(1));
`ifdef SPIKE_CNT_MASK_EN
    // Low byte of neurons only.
    mask = N'(8'hFF);
    for (int i = 0; i < WIN + 4; i++) cycle(1'b1, 1'b0, (i == 2) ? ones : z);
`endif

    // Randomized traffic with occasional halts and resets.
    for (int blk = 0; blk < 10; blk++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
`ifdef SPIKE_CNT_MASK_EN
      mask = rnd_spk(int'($urandom_range(0, 2)));
`endif
      for (int i = 0; i < 80; i++)
        cycle($urandom_range(0, 99) >= 3, $urandom_range(0, 299) == 0, rnd_spk(mode));
    end
    for (int i = 0; i < WIN + 4; i++) cycle(1'b1, 1'b0, rnd_spk(0));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, z);

    for (int d = 0; d < 2; d++) chk(d, "queue_empty", longint'(qs[d].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
